// File: rtl/video_timing_cfg.sv
// Raster timing generator: h/v counters, blanking, sync, display enable and strobes,
// driven by run-time timing registers that are shadowed and swapped only at frame end.
module video_timing_cfg #(
   parameter int HW     = 9,
   parameter int VW     = 9,
   parameter int TW     = 4,
   parameter int HS_POL = 1,
   parameter int VS_POL = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ce_pix,
   input  logic [HW-1:0]        cfg_htotal,
   input  logic [HW-1:0]        cfg_hbl_st,
   input  logic [HW-1:0]        cfg_hbl_end,
   input  logic [HW-1:0]        cfg_hs_st,
   input  logic [HW-1:0]        cfg_hs_len,
   input  logic [VW-1:0]        cfg_vtotal,
   input  logic [VW-1:0]        cfg_vbl_st,
   input  logic [VW-1:0]        cfg_vbl_end,
   input  logic [VW-1:0]        cfg_vs_st,
   input  logic [VW-1:0]        cfg_vs_len,
   input  logic signed [TW-1:0] hs_offset,
   input  logic signed [TW-1:0] hs_width,
   input  logic signed [TW-1:0] vs_offset,
   input  logic signed [TW-1:0] vs_width,
   output logic [HW-1:0]        hc,
   output logic [VW-1:0]        vc,
   output logic                 hbl,
   output logic                 vbl,
   output logic                 hsync,
   output logic                 vsync,
   output logic                 de,
   output logic                 line_start,
   output logic                 frame_start,
   output logic                 vbl_irq
);

   // Three spare bits keep start+offset+length sums from ever wrapping before the clamp.
   localparam int HX = HW + 3;
   localparam int VX = VW + 3;

   logic [HW-1:0]        sh_htotal_reg, sh_hbl_st_reg, sh_hbl_end_reg, sh_hs_st_reg, sh_hs_len_reg;
   logic [VW-1:0]        sh_vtotal_reg, sh_vbl_st_reg, sh_vbl_end_reg, sh_vs_st_reg, sh_vs_len_reg;
   logic signed [TW-1:0] sh_hs_offset_reg, sh_hs_width_reg, sh_vs_offset_reg, sh_vs_width_reg;

   logic [HW-1:0] hc_reg, hc_next;
   logic [VW-1:0] vc_reg, vc_next;
   logic          hbl_reg, hbl_next;
   logic          vbl_reg, vbl_next;
   logic          hs_reg, hs_next;
   logic          vs_reg, vs_next;
   logic          line_start_reg, frame_start_reg, vbl_irq_reg;
   logic          end_of_line, end_of_frame;

   logic signed [HX-1:0] hs_a_x, hs_len_x, hs_b_x;
   logic signed [VX-1:0] vs_a_x, vs_len_x, vs_b_x;
   logic [HW-1:0]        hs_a, hs_b;
   logic [VW-1:0]        vs_a, vs_b;

   function automatic logic [HW-1:0] clamp_h(input logic signed [HX-1:0] v,
                                             input logic [HW-1:0] hi);
      logic signed [HX-1:0] hi_x;
      hi_x = {{(HX-HW){1'b0}}, hi};
      if (v[HX-1])
         clamp_h = '0;
      else if (v > hi_x)
         clamp_h = hi;
      else
         clamp_h = v[HW-1:0];
   endfunction

   function automatic logic [VW-1:0] clamp_v(input logic signed [VX-1:0] v,
                                             input logic [VW-1:0] hi);
      logic signed [VX-1:0] hi_x;
      hi_x = {{(VX-VW){1'b0}}, hi};
      if (v[VX-1])
         clamp_v = '0;
      else if (v > hi_x)
         clamp_v = hi;
      else
         clamp_v = v[VW-1:0];
   endfunction

   // Sync edges: trimmed start clamped to the line, length forced to at least one pixel.
   always_comb begin
      hs_a_x   = {{(HX-HW){1'b0}}, sh_hs_st_reg} + {{(HX-TW){sh_hs_offset_reg[TW-1]}}, sh_hs_offset_reg};
      hs_a     = clamp_h(hs_a_x, sh_htotal_reg);
      hs_len_x = {{(HX-HW){1'b0}}, sh_hs_len_reg} + {{(HX-TW){sh_hs_width_reg[TW-1]}}, sh_hs_width_reg};
      if (hs_len_x[HX-1] || (hs_len_x == '0))
         hs_len_x = {{(HX-1){1'b0}}, 1'b1};
      hs_b_x   = {{(HX-HW){1'b0}}, hs_a} + hs_len_x;
      hs_b     = clamp_h(hs_b_x, sh_htotal_reg);

      vs_a_x   = {{(VX-VW){1'b0}}, sh_vs_st_reg} + {{(VX-TW){sh_vs_offset_reg[TW-1]}}, sh_vs_offset_reg};
      vs_a     = clamp_v(vs_a_x, sh_vtotal_reg);
      vs_len_x = {{(VX-VW){1'b0}}, sh_vs_len_reg} + {{(VX-TW){sh_vs_width_reg[TW-1]}}, sh_vs_width_reg};
      if (vs_len_x[VX-1] || (vs_len_x == '0))
         vs_len_x = {{(VX-1){1'b0}}, 1'b1};
      vs_b_x   = {{(VX-VW){1'b0}}, vs_a} + vs_len_x;
      vs_b     = clamp_v(vs_b_x, sh_vtotal_reg);
   end

   // Next-state from the pre-increment counts; vertical flags only move at line end.
   always_comb begin
      end_of_line  = (hc_reg == sh_htotal_reg);
      end_of_frame = end_of_line && (vc_reg == sh_vtotal_reg);

      hc_next = end_of_line ? '0 : hc_reg + {{(HW-1){1'b0}}, 1'b1};
      vc_next = vc_reg;
      if (end_of_line)
         vc_next = end_of_frame ? '0 : vc_reg + {{(VW-1){1'b0}}, 1'b1};

      hbl_next = hbl_reg;
      if (hc_reg == sh_hbl_st_reg)
         hbl_next = 1'b1;
      else if (hc_reg == sh_hbl_end_reg)
         hbl_next = 1'b0;

      hs_next = hs_reg;
      if (hc_reg == hs_a)
         hs_next = 1'b1;
      else if (hc_reg == hs_b)
         hs_next = 1'b0;

      vbl_next = vbl_reg;
      vs_next  = vs_reg;
      if (end_of_line) begin
         if (vc_reg == sh_vbl_st_reg)
            vbl_next = 1'b1;
         else if (vc_reg == sh_vbl_end_reg)
            vbl_next = 1'b0;
         if (vc_reg == vs_a)
            vs_next = 1'b1;
         else if (vc_reg == vs_b)
            vs_next = 1'b0;
      end
   end

   // Shadow registers swap on the last pixel of the frame so the next frame starts clean.
   always_ff @(posedge clk) begin
      if (reset || (ce_pix && end_of_frame)) begin
         sh_htotal_reg    <= cfg_htotal;
         sh_hbl_st_reg    <= cfg_hbl_st;
         sh_hbl_end_reg   <= cfg_hbl_end;
         sh_hs_st_reg     <= cfg_hs_st;
         sh_hs_len_reg    <= cfg_hs_len;
         sh_vtotal_reg    <= cfg_vtotal;
         sh_vbl_st_reg    <= cfg_vbl_st;
         sh_vbl_end_reg   <= cfg_vbl_end;
         sh_vs_st_reg     <= cfg_vs_st;
         sh_vs_len_reg    <= cfg_vs_len;
         sh_hs_offset_reg <= hs_offset;
         sh_hs_width_reg  <= hs_width;
         sh_vs_offset_reg <= vs_offset;
         sh_vs_width_reg  <= vs_width;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hc_reg          <= '0;
         vc_reg          <= '0;
         hbl_reg         <= 1'b0;
         vbl_reg         <= 1'b0;
         hs_reg          <= 1'b0;
         vs_reg          <= 1'b0;
         line_start_reg  <= 1'b0;
         frame_start_reg <= 1'b0;
         vbl_irq_reg     <= 1'b0;
      end else if (ce_pix) begin
         hc_reg          <= hc_next;
         vc_reg          <= vc_next;
         hbl_reg         <= hbl_next;
         vbl_reg         <= vbl_next;
         hs_reg          <= hs_next;
         vs_reg          <= vs_next;
         line_start_reg  <= end_of_line;
         frame_start_reg <= end_of_frame;
         vbl_irq_reg     <= vbl_next & ~vbl_reg;
      end else begin
         line_start_reg  <= 1'b0;
         frame_start_reg <= 1'b0;
         vbl_irq_reg     <= 1'b0;
      end
   end

   assign hc          = hc_reg;
   assign vc          = vc_reg;
   assign hbl         = hbl_reg;
   assign vbl         = vbl_reg;
   assign hsync       = (HS_POL != 0) ? hs_reg : ~hs_reg;
   assign vsync       = (VS_POL != 0) ? vs_reg : ~vs_reg;
   assign de          = ~hbl_reg & ~vbl_reg;
   assign line_start  = line_start_reg;
   assign frame_start = frame_start_reg;
   assign vbl_irq     = vbl_irq_reg;

endmodule
